// File: rtl/mult_div_unit_if.sv
// -----------------------------------------------------------------------------
// mult_div_unit_if
// Bundles the request, move-to and result signals of the multiply/divide unit.
//
//   start    launch an operation (honoured only while busy = 0)
//   op       00 MULT, 01 MULTU, 10 DIV, 11 DIVU (sampled with start)
//   rs_data  multiplicand / dividend (register-file read_data1)
//   rt_data  multiplier / divisor    (register-file read_data2)
//   wr_hi    MTHI strobe
//   wr_lo    MTLO strobe
//   wr_data  data for MTHI/MTLO
//   busy     operation in progress
//   done     one-cycle completion pulse
//   div_zero one-cycle pulse with done when the divisor was zero
//   hi, lo   HI/LO registers
//
// master: the control unit / register-file side.
// slave : the multiply/divide unit.
// -----------------------------------------------------------------------------
interface mult_div_unit_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] rs_data;
  logic [DATA_W-1:0] rt_data;
  logic              wr_hi;
  logic              wr_lo;
  logic [DATA_W-1:0] wr_data;
  logic              busy;
  logic              done;
  logic              div_zero;
  logic [DATA_W-1:0] hi;
  logic [DATA_W-1:0] lo;

  modport master (
    output start, op, rs_data, rt_data, wr_hi, wr_lo, wr_data,
    input  busy, done, div_zero, hi, lo
  );

  modport slave (
    input  start, op, rs_data, rt_data, wr_hi, wr_lo, wr_data,
    output busy, done, div_zero, hi, lo
  );
endinterface

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
// Iterative radix-2 multiply/divide unit with private HI/LO registers.
// Multiply is shift-add on a 64-bit accumulator; divide is restoring, one
// quotient bit per cycle. Signed operations work on magnitudes and fix the
// signs in a final FIX cycle. Normal latency is 34 cycles (done follows the
// 33rd edge after the start edge); divide by zero finishes one edge after
// start and leaves HI/LO untouched.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset (aborts any operation, clears HI/LO)
//   bus    mult_div_unit_if.slave: start/op/rs_data/rt_data request,
//          wr_hi/wr_lo/wr_data move-to strobes, busy/done/div_zero/hi/lo
//
// Optional build macro:
//   MDU_EARLY_TERM_EN  multiply leaves RUN as soon as the remaining shifted
//                      multiplier magnitude is zero (after at least one step).
//                      Divide timing and all results are unaffected.
// -----------------------------------------------------------------------------
module mult_div_unit #(
  parameter int DATA_W = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  mult_div_unit_if.slave       bus
);

  localparam int CNT_W = $clog2(DATA_W);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FIX   = 2'd2,
    ZDONE = 2'd3
  } state_t;

  state_t state_reg, state_next;

  // Operation context captured at start
  logic                  is_div_reg;
  logic                  neg_q_reg;     // product / quotient must be negated
  logic                  neg_r_reg;     // remainder must be negated (dividend sign)
  logic [CNT_W-1:0]      cnt_reg;

  // Datapath. For multiply acc_reg is the product accumulator; for divide the
  // upper half is the partial remainder and the lower half shifts the dividend
  // out while the quotient bits shift in.
  logic [2*DATA_W-1:0]   acc_reg;
  logic [2*DATA_W-1:0]   mcand_reg;     // multiplicand magnitude, shifted left each step
  logic [DATA_W:0]       mplier_reg;    // multiplier magnitude, shifted right each step
  logic [DATA_W-1:0]     dvsr_reg;      // divisor magnitude

  logic [DATA_W-1:0]     hi_reg;
  logic [DATA_W-1:0]     lo_reg;
  logic                  done_reg;
  logic                  div_zero_reg;

  // ---------------------------------------------------------------------------
  // Operand decode. Magnitudes are formed in DATA_W+1 bits so that the most
  // negative value maps to +2^(DATA_W-1) without overflow.
  // ---------------------------------------------------------------------------
  logic              op_signed;
  logic              op_div;
  logic              sign_a;
  logic              sign_b;
  logic [DATA_W:0]   ext_a;
  logic [DATA_W:0]   ext_b;
  logic [DATA_W:0]   a_mag;
  logic [DATA_W:0]   b_mag;

  always_comb begin
    op_signed = ~bus.op[0];
    op_div    = bus.op[1];
    sign_a    = op_signed & bus.rs_data[DATA_W-1];
    sign_b    = op_signed & bus.rt_data[DATA_W-1];
    ext_a     = {sign_a, bus.rs_data};
    ext_b     = {sign_b, bus.rt_data};
    a_mag     = sign_a ? -ext_a : ext_a;
    b_mag     = sign_b ? -ext_b : ext_b;
  end

  // ---------------------------------------------------------------------------
  // One iteration step
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0]   mul_acc_next;
  logic [DATA_W:0]       mplier_next;
  logic [DATA_W:0]       rem_shift;
  logic                  rem_ge;
  logic [DATA_W-1:0]     rem_diff;
  logic [2*DATA_W-1:0]   div_acc_next;
  logic                  last_step;

  always_comb begin
    // Multiply: add the shifted multiplicand when the current multiplier bit is set
    mul_acc_next = mplier_reg[0] ? (acc_reg + mcand_reg) : acc_reg;
    mplier_next  = mplier_reg >> 1;

    // Divide: bring down the next dividend bit, subtract if it fits.
    // When rem_ge holds the difference is below the divisor, so the low
    // DATA_W bits of the subtraction are the complete new remainder.
    rem_shift    = {acc_reg[2*DATA_W-1:DATA_W], acc_reg[DATA_W-1]};
    rem_ge       = (rem_shift >= {1'b0, dvsr_reg});
    rem_diff     = rem_shift[DATA_W-1:0] - dvsr_reg;
    div_acc_next = {(rem_ge ? rem_diff : rem_shift[DATA_W-1:0]),
                    acc_reg[DATA_W-2:0], rem_ge};

`ifdef MDU_EARLY_TERM_EN
    last_step = (cnt_reg == CNT_LAST) || (!is_div_reg && (mplier_next == '0));
`else
    last_step = (cnt_reg == CNT_LAST);
`endif
  end

  // ---------------------------------------------------------------------------
  // Sign correction applied in FIX
  // ---------------------------------------------------------------------------
  logic [2*DATA_W-1:0]   prod_fix;
  logic [DATA_W-1:0]     quot_fix;
  logic [DATA_W-1:0]     rem_fix;

  always_comb begin
    prod_fix = neg_q_reg ? -acc_reg : acc_reg;
    quot_fix = neg_q_reg ? -acc_reg[DATA_W-1:0] : acc_reg[DATA_W-1:0];
    rem_fix  = neg_r_reg ? -acc_reg[2*DATA_W-1:DATA_W] : acc_reg[2*DATA_W-1:DATA_W];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          if (op_div && (bus.rt_data == '0)) begin
            state_next = ZDONE;
          end else begin
            state_next = RUN;
          end
        end
      end
      RUN: begin
        if (last_step) begin
          state_next = FIX;
        end
      end
      FIX:     state_next = IDLE;
      ZDONE:   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath and result registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      is_div_reg   <= 1'b0;
      neg_q_reg    <= 1'b0;
      neg_r_reg    <= 1'b0;
      cnt_reg      <= '0;
      acc_reg      <= '0;
      mcand_reg    <= '0;
      mplier_reg   <= '0;
      dvsr_reg     <= '0;
      hi_reg       <= '0;
      lo_reg       <= '0;
      done_reg     <= 1'b0;
      div_zero_reg <= 1'b0;
    end else begin
      done_reg     <= (state_reg == FIX) || (state_reg == ZDONE);
      div_zero_reg <= (state_reg == ZDONE);

      case (state_reg)
        IDLE: begin
          // Move-to writes land first; a result started in the same cycle
          // overwrites them later in FIX.
          if (bus.wr_hi) begin
            hi_reg <= bus.wr_data;
          end
          if (bus.wr_lo) begin
            lo_reg <= bus.wr_data;
          end
          if (bus.start) begin
            is_div_reg <= op_div;
            neg_q_reg  <= sign_a ^ sign_b;
            neg_r_reg  <= sign_a;
            cnt_reg    <= '0;
            if (op_div) begin
              acc_reg    <= {{DATA_W{1'b0}}, a_mag[DATA_W-1:0]};
              dvsr_reg   <= b_mag[DATA_W-1:0];
              mcand_reg  <= '0;
              mplier_reg <= '0;
            end else begin
              acc_reg    <= '0;
              mcand_reg  <= {{(DATA_W-1){1'b0}}, a_mag};
              mplier_reg <= b_mag;
              dvsr_reg   <= '0;
            end
          end
        end

        RUN: begin
          cnt_reg <= cnt_reg + 1'b1;
          if (is_div_reg) begin
            acc_reg <= div_acc_next;
          end else begin
            acc_reg    <= mul_acc_next;
            mcand_reg  <= mcand_reg << 1;
            mplier_reg <= mplier_next;
          end
        end

        FIX: begin
          cnt_reg <= '0;
          if (is_div_reg) begin
            hi_reg <= rem_fix;
            lo_reg <= quot_fix;
          end else begin
            hi_reg <= prod_fix[2*DATA_W-1:DATA_W];
            lo_reg <= prod_fix[DATA_W-1:0];
          end
        end

        default: begin
          // ZDONE: HI/LO are left as they were
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign bus.busy     = (state_reg != IDLE);
  assign bus.done     = done_reg;
  assign bus.div_zero = div_zero_reg;
  assign bus.hi       = hi_reg;
  assign bus.lo       = lo_reg;

endmodule

// File: tb/tb_mult_div_unit.sv
// -----------------------------------------------------------------------------
// tb_mult_div_unit
// Directed self-checking bench for mult_div_unit. Inputs are driven and
// outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mult_div_unit;

  localparam int DATA_W = 32;
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  logic clk;
  logic rst_n;

  int n_compared = 0;
  int n_mismatch = 0;

  mult_div_unit_if #(.DATA_W(DATA_W)) bus ();

  mult_div_unit #(.DATA_W(DATA_W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_compared++;
    if (obs !== exp) begin
      n_mismatch++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Expected start-to-done edge count for a multiply with the given
  // multiplier magnitude.
  function automatic int mul_lat(input logic [31:0] mag);
    int steps;
`ifdef MDU_EARLY_TERM_EN
    steps = 1;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) steps = i + 1;
    end
`else
    steps = 32;
    if (mag == 32'h0) steps = 32;
`endif
    return steps + 1;
  endfunction

  // Present a start for one cycle; returns at the falling edge after E0.
  task automatic start_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    @(negedge clk);
    bus.start   = 1'b1;
    bus.op      = op;
    bus.rs_data = a;
    bus.rt_data = b;
    @(negedge clk);
    bus.start   = 1'b0;
    bus.rs_data = 32'hDEAD_BEEF;
    bus.rt_data = 32'h0BAD_F00D;
  endtask

  // Count falling edges until done; n0 is the edge index already reached.
  task automatic wait_done(input string tag, input int n0, output int n);
    n = n0;
    while (bus.done !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check({tag, "_timeout"}, 64'(n), 64'(0));
  endtask

  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo,
                        input int exp_lat, input logic exp_dz);
    int n;
    start_op(op, a, b);
    check({tag, "_busy"}, 64'(bus.busy), 64'(1));
    wait_done(tag, 0, n);
    check({tag, "_lat"}, 64'(n), 64'(exp_lat));
    check({tag, "_hi"}, 64'(bus.hi), 64'(exp_hi));
    check({tag, "_lo"}, 64'(bus.lo), 64'(exp_lo));
    check({tag, "_dz"}, 64'(bus.div_zero), 64'(exp_dz));
    check({tag, "_busy_done"}, 64'(bus.busy), 64'(0));
    $display("txn %-10s op=%0d a=%08h b=%08h -> hi=%08h lo=%08h lat=%0d dz=%0b",
             tag, op, a, b, bus.hi, bus.lo, n, bus.div_zero);
    @(negedge clk);
    check({tag, "_pulse"}, 64'(bus.done), 64'(0));
  endtask

  initial begin
    int n;
    int done_cnt;

    bus.start   = 1'b0;
    bus.op      = 2'b00;
    bus.rs_data = '0;
    bus.rt_data = '0;
    bus.wr_hi   = 1'b0;
    bus.wr_lo   = 1'b0;
    bus.wr_data = '0;
    rst_n       = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Reset state
    check("rst_busy", 64'(bus.busy), 64'(0));
    check("rst_done", 64'(bus.done), 64'(0));
    check("rst_dz",   64'(bus.div_zero), 64'(0));
    check("rst_hi",   64'(bus.hi), 64'(0));
    check("rst_lo",   64'(bus.lo), 64'(0));

    // Preload both with one strobe pair, then abort a MULTU 7x9 by reset
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_lo = 1'b1; bus.wr_data = 32'h77;
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b0;
    check("mt_both_hi", 64'(bus.hi), 64'h77);
    check("mt_both_lo", 64'(bus.lo), 64'h77);
    start_op(OP_MULTU, 32'd7, 32'd9);
    repeat (3) @(negedge clk);
    check("abort_busy_pre", 64'(bus.busy), 64'(1));
    #2 rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(bus.busy), 64'(0));
    check("abort_hi",   64'(bus.hi), 64'(0));
    check("abort_lo",   64'(bus.lo), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    done_cnt = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done === 1'b1) done_cnt++;
    end
    check("abort_no_done", 64'(done_cnt), 64'(0));
    $display("txn %-10s reset mid-RUN hi=%08h lo=%08h", "abort", bus.hi, bus.lo);

    // MULTU max x max with an ignored start at E5 (different op and operands)
    start_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    repeat (4) @(negedge clk);
    bus.start = 1'b1; bus.op = OP_DIVU; bus.rs_data = 32'd100; bus.rt_data = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    wait_done("multu_max", 5, n);
    check("multu_max_lat", 64'(n), 64'(33));
    check("multu_max_hi", 64'(bus.hi), 64'hFFFF_FFFE);
    check("multu_max_lo", 64'(bus.lo), 64'h0000_0001);
    $display("txn %-10s hi=%08h lo=%08h lat=%0d", "multu_max", bus.hi, bus.lo, n);
    @(negedge clk);
    check("multu_max_no_requeue", 64'(bus.busy), 64'(0));

    // Signed and unsigned arithmetic
    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFF9, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFEB, mul_lat(32'd3), 1'b0);
    run_op("mult_min",  OP_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, mul_lat(32'h8000_0000), 1'b0);
    run_op("multu_5x3", OP_MULTU, 32'd5,         32'd3,         32'h0,         32'd15,        mul_lat(32'd3), 1'b0);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("div_negd",  OP_DIV,   32'd7,         32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 33, 1'b0);
    run_op("divu_100",  OP_DIVU,  32'd100,       32'd7,         32'd2,         32'd14,        33, 1'b0);
    run_op("div_wrap",  OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         32'h8000_0000, 33, 1'b0);

    // Divide by zero leaves preloaded HI/LO intact
    @(negedge clk);
    bus.wr_hi = 1'b1; bus.wr_data = 32'hAAAA;
    @(negedge clk);
    bus.wr_hi = 1'b0; bus.wr_lo = 1'b1; bus.wr_data = 32'h5555;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    check("mthi", 64'(bus.hi), 64'hAAAA);
    check("mtlo", 64'(bus.lo), 64'h5555);
    run_op("divu_zero", OP_DIVU, 32'd9, 32'd0, 32'hAAAA, 32'h5555, 1, 1'b1);
    check("divu_zero_dz_pulse", 64'(bus.div_zero), 64'(0));

    // MTLO while busy is ignored; back-to-back start in the done cycle
    start_op(OP_MULTU, 32'd6, 32'h4000_0000);
    repeat (3) @(negedge clk);
    bus.wr_lo = 1'b1; bus.wr_data = 32'h1234;
    @(negedge clk);
    bus.wr_lo = 1'b0;
    check("mtlo_busy_lo", 64'(bus.lo), 64'h5555);
    wait_done("b2b_first", 4, n);
    check("b2b_first_lat", 64'(n), 64'(mul_lat(32'h4000_0000)));
    check("b2b_first_hi", 64'(bus.hi), 64'h1);
    check("b2b_first_lo", 64'(bus.lo), 64'h8000_0000);
    $display("txn %-10s hi=%08h lo=%08h lat=%0d", "b2b_first", bus.hi, bus.lo, n);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.rs_data = 32'd2; bus.rt_data = 32'd3;
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b_busy", 64'(bus.busy), 64'(1));
    check("b2b_done_low", 64'(bus.done), 64'(0));
    wait_done("b2b_second", 0, n);
    check("b2b_second_lat", 64'(n), 64'(mul_lat(32'd3)));
    check("b2b_second_hi", 64'(bus.hi), 64'h0);
    check("b2b_second_lo", 64'(bus.lo), 64'h6);
    $display("txn %-10s hi=%08h lo=%08h lat=%0d", "b2b_second", bus.hi, bus.lo, n);

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatch);
    $finish;
  end

endmodule

// File: doc/mult_div_unit.md
Name: mult_div_unit

Overview:
- Iterative multiply/divide unit for the MIPS-style datapath. Sits directly downstream of the register file.
- Consumes the RS/RT read-data pair for MULT/MULTU/DIV/DIVU and holds results in private HI/LO registers; MFHI/MFLO read those registers.
- Needed by bucket sort for bucket-index division.
- Runs multi-cycle; the control unit stalls on `busy`.

Parameters:
- DATA_W, 32, operand width and width of each of HI and LO; tested only at 32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous, active-low reset
- start  input  1  launch operation; honoured only when busy=0
- op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with start
- rs_data  input  DATA_W  multiplicand / dividend, from register-file read_data1
- rt_data  input  DATA_W  multiplier / divisor, from register-file read_data2
- wr_hi  input  1  MTHI strobe
- wr_lo  input  1  MTLO strobe
- wr_data  input  DATA_W  data for MTHI/MTLO
- busy  output  1  operation in progress
- done  output  1  one-cycle completion pulse
- div_zero  output  1  one-cycle pulse coincident with done when divisor = 0
- hi  output  DATA_W  HI register (product[63:32] / remainder)
- lo  output  DATA_W  LO register (product[31:0] / quotient)

Behaviour:
- Reset (rst_n low, asynchronous):
  - state=IDLE; hi=0, lo=0.
  - busy=0, done=0, div_zero=0; iteration counter=0.
  - Reset mid-operation aborts it; no result is written.
- States and transitions:
  - IDLE: start=1 latches op and operands.
    - Signed ops (MULT, DIV) convert operands to magnitudes and record signs.
    - DIV/DIVU with rt_data=0 goes to ZDONE; otherwise goes to RUN with counter=0.
  - RUN: one radix-2 step per cycle.
    - Multiply: shift-add on 64-bit accumulator.
    - Divide: restoring, one quotient bit per cycle.
    - After 32 steps (counter==31) goes to FIX.
  - FIX:
    - Applies signs: product negated if signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
    - Writes hi/lo, pulses done, returns to IDLE.
  - ZDONE: hi/lo unchanged; done=1 and div_zero=1 for one cycle; returns to IDLE.
- Timing (start sampled at edge E0):
  - busy=1 from after E0 through the cycle before done.
  - Normal op: hi/lo updated and done=1 in the cycle after edge E33. Latency 34 cycles.
  - Divide by zero: done after E1.
  - busy=0 in the done cycle, so a new start may be accepted in that cycle.
- Handshake and strobe rules:
  - start while busy=1 is ignored; no queuing.
  - Operands need only be valid in the start cycle.
  - wr_hi/wr_lo write hi/lo at the next edge only when busy=0; ignored while busy.
  - If wr_hi/wr_lo and start occur in the same IDLE cycle, the MT write happens, then the operation's result overwrites at completion.
  - wr_hi and wr_lo in the same cycle write both.
- Arithmetic:
  - Magnitude of 0x80000000 is 2^31, held in 33 bits internally.
  - MULT 0x80000000 × 0x80000000 gives hi=0x40000000, lo=0.
  - DIV 0x80000000 / 0xFFFFFFFF gives lo=0x80000000 (wraps), hi=0.
  - MULTU/DIVU treat operands as unsigned.
- hi/lo are registered outputs and hold steady between writes.

Optional Feature:
- Macro: MDU_EARLY_TERM_EN.
- With the macro defined, multiply leaves RUN early once the remaining shifted multiplier magnitude is zero after at least one step.
  - RUN lasts max(1, index of MSB of |rt|+1) cycles.
  - Example: MULTU 5×3 takes 2 RUN cycles, so done follows edge E3.
  - Divide timing and all results are unchanged.
- Without the macro, every multiply takes exactly 32 RUN cycles.

Test Plan:
1. Reset: rst_n low mid-RUN of MULTU 7×9 -> busy=0, hi=0, lo=0 immediately; no done pulse afterwards.
2. MULTU 0xFFFFFFFF×0xFFFFFFFF -> done after E33, hi=0xFFFFFFFE, lo=0x00000001; start at E5 (while busy) ignored.
3. MULT -7×3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB; MULT 0x80000000×0x80000000 -> hi=0x40000000, lo=0.
4. DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIVU 100/7 -> lo=14, hi=2; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
5. Preload MTHI=0xAAAA, MTLO=0x5555; then DIVU 9/0 -> done and div_zero after E1, hi=0xAAAA, lo=0x5555 unchanged.
6. wr_lo=1 with wr_data=0x1234 while busy -> lo unchanged; back-to-back start in done cycle accepted, busy stays 1 the next cycle.
